// File: rtl/mult_product_accumulator.sv
// Accumulates a programmed number of unsigned multiplier products into a wide sum,
// taking products over valid/ready and presenting the result over valid/ack.
module mult_product_accumulator #(
  parameter int PROD_W = 32,
  parameter int ACC_W  = 40,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [CNT_W-1:0]  num_terms,
  input  logic [PROD_W-1:0] prod_in,
  input  logic              prod_valid,
  output logic              prod_ready,
  output logic [ACC_W-1:0]  acc_out,
  output logic              acc_valid,
  input  logic              acc_ack,
  output logic              ovf,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [ACC_W-1:0] acc;
  logic [CNT_W-1:0] count;
  logic [ACC_W:0]   sum;
  logic             xfer;
  logic             last;

  // One extra bit on the adder exposes the carry out of the accumulator.
  assign sum  = {1'b0, acc} + (ACC_W + 1)'(prod_in);
  assign xfer = (state == ACCUM) && prod_valid;
  assign last = xfer && (count == CNT_W'(1));

  always_comb begin
    // NOTE: next state defaults to the current state before the case, so no path leaves it unassigned and no latch is inferred.
    state_nxt = state;
    unique case (state)
      IDLE: begin
        if (start) begin
          state_nxt = (num_terms == '0) ? DONE : ACCUM;
        end
      end
      ACCUM: begin
        if (last) begin
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (acc_ack) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // NOTE: sequential state is written with non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // NOTE: datapath registers share the synchronous reset so an aborted sequence leaves no stale sum or flag visible.
  always_ff @(posedge clk) begin
    if (!rst) begin
      acc     <= '0;
      count   <= '0;
      acc_out <= '0;
      ovf     <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            ovf <= 1'b0;
            if (num_terms != '0) begin
              acc   <= '0;
              count <= num_terms;
            end else begin
              acc_out <= '0;
            end
          end
        end
        ACCUM: begin
          if (xfer) begin
            acc   <= sum[ACC_W-1:0];
            count <= count - CNT_W'(1);
            if (sum[ACC_W]) begin
              ovf <= 1'b1;
            end
            if (count == CNT_W'(1)) begin
              acc_out <= sum[ACC_W-1:0];
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign prod_ready = (state == ACCUM);
  assign acc_valid  = (state == DONE);
  assign busy       = (state != IDLE);

endmodule

// File: tb/tb_mult_product_accumulator.sv
// Directed bench for mult_product_accumulator: a 40-bit and a 33-bit accumulator
// share one stimulus stream; a vector table plus hand-written control sequences.
module tb_mult_product_accumulator;

  logic        clk;
  logic        rst;
  logic        start;
  logic [7:0]  num_terms;
  logic [31:0] prod_in;
  logic        prod_valid;
  logic        acc_ack;

  logic        prod_ready40, acc_valid40, ovf40, busy40;
  logic [39:0] acc_out40;
  logic        prod_ready33, acc_valid33, ovf33, busy33;
  logic [32:0] acc_out33;

  int tests = 0;
  int fails = 0;

  mult_product_accumulator #(.PROD_W(32), .ACC_W(40), .CNT_W(8)) dut40 (
    .clk(clk), .rst(rst), .start(start), .num_terms(num_terms),
    .prod_in(prod_in), .prod_valid(prod_valid), .prod_ready(prod_ready40),
    .acc_out(acc_out40), .acc_valid(acc_valid40), .acc_ack(acc_ack),
    .ovf(ovf40), .busy(busy40)
  );

  mult_product_accumulator #(.PROD_W(32), .ACC_W(33), .CNT_W(8)) dut33 (
    .clk(clk), .rst(rst), .start(start), .num_terms(num_terms),
    .prod_in(prod_in), .prod_valid(prod_valid), .prod_ready(prod_ready33),
    .acc_out(acc_out33), .acc_valid(acc_valid33), .acc_ack(acc_ack),
    .ovf(ovf33), .busy(busy33)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    int unsigned n;
    logic [31:0] base;
    logic [31:0] stride;
    bit          gap;
    logic [39:0] exp40;
    logic        ovf40;
    logic [32:0] exp33;
    logic        ovf33;
  } vec_t;

  vec_t vecs[7];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Runs one full start / transfer / ack sequence and checks both accumulators.
  task automatic run_seq(input vec_t v, input string tag);
    start     = 1'b1;
    num_terms = 8'(v.n);
    step();
    start = 1'b0;
    check({tag, ".ovf40_clear"}, 64'(ovf40), 64'(0));
    check({tag, ".ovf33_clear"}, 64'(ovf33), 64'(0));
    if (v.n == 0) begin
      check({tag, ".zero_done"}, 64'(acc_valid40), 64'(1));
      check({tag, ".zero_ready"}, 64'(prod_ready40), 64'(0));
    end else begin
      check({tag, ".busy"}, 64'(busy40), 64'(1));
      for (int i = 0; i < int'(v.n); i++) begin
        if (v.gap) begin
          prod_valid = 1'b0;
          step();
          check({tag, ".ready_gap"}, 64'(prod_ready40), 64'(1));
        end
        check({tag, ".ready"}, 64'(prod_ready40), 64'(1));
        check({tag, ".valid_early"}, 64'(acc_valid40), 64'(0));
        prod_in    = v.base + v.stride * 32'(i);
        prod_valid = 1'b1;
        step();
      end
      prod_valid = 1'b0;
      prod_in    = '0;
      check({tag, ".valid40_lat1"}, 64'(acc_valid40), 64'(1));
      check({tag, ".valid33_lat1"}, 64'(acc_valid33), 64'(1));
      check({tag, ".ready_done"}, 64'(prod_ready40), 64'(0));
    end
    check({tag, ".acc40"}, 64'(acc_out40), 64'(v.exp40));
    check({tag, ".ovf40"}, 64'(ovf40), 64'(v.ovf40));
    check({tag, ".acc33"}, 64'(acc_out33), 64'(v.exp33));
    check({tag, ".ovf33"}, 64'(ovf33), 64'(v.ovf33));
    step();
    check({tag, ".hold_valid"}, 64'(acc_valid40), 64'(1));
    check({tag, ".hold_acc"}, 64'(acc_out40), 64'(v.exp40));
    check({tag, ".hold_ovf33"}, 64'(ovf33), 64'(v.ovf33));
    acc_ack = 1'b1;
    step();
    acc_ack = 1'b0;
    check({tag, ".ack_valid"}, 64'(acc_valid40), 64'(0));
    check({tag, ".ack_busy"}, 64'(busy40), 64'(0));
  endtask

  initial begin
    vecs[0] = '{n: 3,   base: 32'd10,         stride: 32'd10, gap: 1'b0,
                exp40: 40'd60,           ovf40: 1'b0, exp33: 33'd60,          ovf33: 1'b0};
    vecs[1] = '{n: 4,   base: 32'd1,          stride: 32'd1,  gap: 1'b1,
                exp40: 40'd10,           ovf40: 1'b0, exp33: 33'd10,          ovf33: 1'b0};
    vecs[2] = '{n: 1,   base: 32'h1234_5678,  stride: 32'd0,  gap: 1'b0,
                exp40: 40'h12345678,     ovf40: 1'b0, exp33: 33'h12345678,    ovf33: 1'b0};
    vecs[3] = '{n: 255, base: 32'hFFFF_FFFF,  stride: 32'd0,  gap: 1'b0,
                exp40: 40'hFE_FFFF_FF01, ovf40: 1'b0, exp33: 33'h0_FFFF_FF01, ovf33: 1'b1};
    vecs[4] = '{n: 3,   base: 32'hFFFF_FFFF,  stride: 32'd0,  gap: 1'b0,
                exp40: 40'h02_FFFF_FFFD, ovf40: 1'b0, exp33: 33'h0_FFFF_FFFD, ovf33: 1'b1};
    vecs[5] = '{n: 0,   base: 32'd0,          stride: 32'd0,  gap: 1'b0,
                exp40: 40'd0,            ovf40: 1'b0, exp33: 33'd0,           ovf33: 1'b0};
    vecs[6] = '{n: 2,   base: 32'd7,          stride: 32'd1,  gap: 1'b0,
                exp40: 40'd15,           ovf40: 1'b0, exp33: 33'd15,          ovf33: 1'b0};

    rst        = 1'b0;
    start      = 1'b0;
    num_terms  = '0;
    prod_in    = '0;
    prod_valid = 1'b0;
    acc_ack    = 1'b0;
    step();
    step();
    check("rst.acc_out", 64'(acc_out40), 64'(0));
    check("rst.acc_valid", 64'(acc_valid40), 64'(0));
    check("rst.ovf", 64'(ovf40), 64'(0));
    check("rst.busy", 64'(busy40), 64'(0));
    check("rst.prod_ready", 64'(prod_ready40), 64'(0));
    rst = 1'b1;
    step();

    for (int k = 0; k < 7; k++) begin
      run_seq(vecs[k], $sformatf("vec%0d", k));
    end

    // Reset in the middle of a 5-term sequence, then a fresh 2-term sum.
    start     = 1'b1;
    num_terms = 8'd5;
    step();
    start = 1'b0;
    for (int i = 0; i < 2; i++) begin
      prod_in    = 32'd100;
      prod_valid = 1'b1;
      step();
    end
    check("midrst.busy_before", 64'(busy40), 64'(1));
    rst = 1'b0;
    step();
    check("midrst.acc_out", 64'(acc_out40), 64'(0));
    check("midrst.acc_valid", 64'(acc_valid40), 64'(0));
    check("midrst.ovf", 64'(ovf40), 64'(0));
    check("midrst.busy", 64'(busy40), 64'(0));
    check("midrst.prod_ready", 64'(prod_ready40), 64'(0));
    rst        = 1'b1;
    prod_valid = 1'b0;
    step();
    check("midrst.idle", 64'(busy40), 64'(0));
    run_seq(vecs[6], "after_rst");

    // start held high through ACCUM and DONE must not reload or restart.
    start     = 1'b1;
    num_terms = 8'd2;
    step();
    num_terms = 8'd9;
    prod_in    = 32'd100;
    prod_valid = 1'b1;
    step();
    prod_in = 32'd200;
    step();
    prod_valid = 1'b0;
    check("ign.valid", 64'(acc_valid40), 64'(1));
    check("ign.acc", 64'(acc_out40), 64'(300));
    step();
    check("ign.done_hold", 64'(acc_valid40), 64'(1));
    check("ign.done_acc", 64'(acc_out40), 64'(300));
    acc_ack = 1'b1;
    step();
    check("ign.ack_start_idle", 64'(busy40), 64'(0));
    check("ign.ack_start_valid", 64'(acc_valid40), 64'(0));
    start = 1'b0;
    step();
    check("ign.stay_idle", 64'(busy40), 64'(0));
    acc_ack    = 1'b0;
    prod_valid = 1'b1;
    step();
    check("ign.idle_ready", 64'(prod_ready40), 64'(0));
    check("ign.idle_busy", 64'(busy40), 64'(0));
    prod_valid = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
